case_8_mul_pipe_sat: RTL
========================

// Module: case_8_mul_pipe_sat
// PURPOSE
//  Pipelined signed multiplier with valid/ready handshake, the successor to the fixed combinational
//  multiply cells. Adds configurable pipeline depth, optional rounded right-shift of the product and
//  wrap or saturate narrowing, plus a sticky overflow flag. Sits between HLS datapath stages that
//  need back-pressure.
// PARAMETERS
//  ID          1   instance tag, no functional effect
//  NUM_STAGE   2   pipeline depth in cycles, >=1
//  din0_WIDTH  11  signed operand A width
//  din1_WIDTH  7   signed operand B width
//  dout_WIDTH  11  signed result width
//  SHIFT       0   arithmetic right shift applied to the full product, 0..din0_WIDTH+din1_WIDTH-1
//  SAT         0   0 = wrap (keep low dout_WIDTH bits), 1 = saturate to signed dout range
// PORTS
//  ap_clk     in   1           clock, rising edge
//  ap_rst_n   in   1           asynchronous active-low reset
//  in_valid   in   1           din0/din1 valid
//  in_ready   out  1           block accepts input this cycle
//  din0       in   din0_WIDTH  signed operand A
//  din1       in   din1_WIDTH  signed operand B
//  out_valid  out  1           dout valid
//  out_ready  in   1           downstream accepts dout
//  dout       out  dout_WIDTH  signed result
//  ovf        out  1           sticky: set when any emitted result was clipped or wrapped
//  clr_ovf    in   1           synchronous clear of ovf
// BEHAVIOUR
//  - Reset (ap_rst_n=0, async): all stage valid bits=0, out_valid=0, dout=0, ovf=0. Data regs=0.
//  - Global advance: ce = ~out_valid | out_ready. in_ready = ce, combinational. When ce=0 every stage holds.
//  - Input accepted when in_valid & in_ready. Stage-1 valid loads in_valid&in_ready on ce. Later valids shift on ce.
//  - Bubbles are not collapsed; the pipeline is a lock-step shift register.
//  - Latency: exactly NUM_STAGE ap_clk edges from acceptance to out_valid=1 with no stall. Throughput 1/cycle.
//  - out_valid/dout held stable while out_valid & ~out_ready (AXI-style). dout undefined-but-stable when out_valid=0.
//  - Arithmetic:
//    - P = din0_WIDTH+din1_WIDTH bit full signed product.
//    - If SHIFT>0: r = (P + 2^(SHIFT-1)) >>> SHIFT in P+1 bits (round half up toward +inf). Else r = P.
//  - Narrowing SAT=0: dout = r[dout_WIDTH-1:0].
//  - Narrowing SAT=1: r > 2^(dout_WIDTH-1)-1 gives max; r < -2^(dout_WIDTH-1) gives min; else r.
//  - ovf sets on the cycle a result is loaded into the output stage and that result exceeds the dout range.
//    This applies in either mode. ovf stays set until clr_ovf=1.
//  - clr_ovf and a new overflow in the same cycle: ovf=1 (set wins).
//  - Multiply is placed between stage 1 and the last stage. For NUM_STAGE=1 it is combinational from
//    inputs to the single output register.
//  - Reset mid-operation: all in-flight results are dropped, no partial output. in_ready=1 the cycle after
//    release (out_valid=0).
// TESTING
//  - Defaults, SAT=0: din0=1023, din1=63 -> two cycles later out_valid=1, dout=961 (64449 wrapped), ovf=1.
//  - SAT=1: din0=1023, din1=63 -> dout=1023. din0=-1024, din1=-64 -> dout=1023. din0=-1024, din1=63 -> dout=-1024.
//    ovf=1 after each; clr_ovf pulse -> ovf=0.
//  - SHIFT=4, SAT=1: din0=100, din1=3 -> dout=19. din0=-100, din1=3 -> dout=-19. din0=8, din1=1 -> dout=1. ovf stays 0.
//  - Back-pressure: stream 5 operands back-to-back, hold out_ready=0 for 3 cycles mid-stream.
//    Required: in_ready=0 during the hold, dout stable, all 5 results emitted in order, none lost or duplicated.
//  - Reset mid-stream: assert ap_rst_n=0 with 2 results in flight.
//    Required: out_valid=0 and ovf=0 immediately; no stale result emitted after release.
//  - NUM_STAGE=1 and NUM_STAGE=4 sweep with random operands vs reference model, continuous out_ready and
//    random out_ready toggling.

Source files
------------

// File: rtl/case_8_mul_pipe_sat.sv
// Pipelined signed multiplier with valid/ready back-pressure, optional rounded right shift,
// wrap or saturate narrowing to dout_WIDTH, and a sticky overflow flag.
module case_8_mul_pipe_sat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 7,
  parameter int dout_WIDTH = 11,
  parameter int SHIFT      = 0,
  parameter int SAT        = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  input  logic                  clr_ovf
);

  localparam int PW    = din0_WIDTH + din1_WIDTH;
  // Headroom so the product, rounding add and range compares never overflow.
  localparam int EW    = PW + dout_WIDTH + 2;
  localparam int RS    = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
  localparam int SH_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [EW-1:0] RND   = (SHIFT > 0) ? (EW'(1) << SH_M1) : '0;
  localparam logic signed [EW-1:0] MAX_V = (EW'(1) << (dout_WIDTH - 1)) - EW'(1);
  localparam logic signed [EW-1:0] MIN_V = -(EW'(1) << (dout_WIDTH - 1));

  logic                  ce;
  logic                  accept;
  logic [din0_WIDTH-1:0] op_a;
  logic [din1_WIDTH-1:0] op_b;
  logic                  op_v;

  logic signed [EW-1:0]  a_ext;
  logic signed [EW-1:0]  b_ext;
  logic signed [EW-1:0]  prod;
  logic signed [EW-1:0]  rnd_sum;
  logic signed [EW-1:0]  r_full;
  logic [dout_WIDTH-1:0] res_n;
  logic                  ovf_n;

  // The whole pipeline advances in lock step; a stalled output freezes every stage.
  assign ce       = ~out_valid | out_ready;
  assign in_ready = ce;
  assign accept   = in_valid & ce;

  generate
    if (NUM_STAGE > 1) begin : g_op_reg
      logic [din0_WIDTH-1:0] a_q, a_d;
      logic [din1_WIDTH-1:0] b_q, b_d;
      logic                  v_q, v_d;

      always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        a_d = a_q;
        b_d = b_q;
        v_d = v_q;
        if (ce) begin
          a_d = din0;
          b_d = din1;
          v_d = accept;
        end
      end

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample together.
        if (!ap_rst_n) begin
          a_q <= '0;
          b_q <= '0;
          v_q <= 1'b0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
          v_q <= v_d;
        end
      end

      assign op_a = a_q;
      assign op_b = b_q;
      assign op_v = v_q;
    end else begin : g_op_comb
      assign op_a = din0;
      assign op_b = din1;
      assign op_v = accept;
    end
  endgenerate

  always_comb begin
    a_ext   = EW'($signed(op_a));
    b_ext   = EW'($signed(op_b));
    prod    = a_ext * b_ext;
    // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
    rnd_sum = prod + RND;
    r_full  = rnd_sum >>> SHIFT;
    ovf_n   = (r_full > MAX_V) || (r_full < MIN_V);
    res_n   = r_full[dout_WIDTH-1:0];
    if (SAT != 0) begin
      if (r_full > MAX_V) begin
        res_n = MAX_V[dout_WIDTH-1:0];
      end else if (r_full < MIN_V) begin
        res_n = MIN_V[dout_WIDTH-1:0];
      end
    end
  end

  // Result stages: entry RS-1 is the output register.
  logic [dout_WIDTH-1:0] res_q [RS];
  logic [dout_WIDTH-1:0] res_d [RS];
  logic [RS-1:0]         rv_q, rv_d;
  logic [RS-1:0]         rf_q, rf_d;
  logic                  ovf_q, ovf_d;

  always_comb begin
    res_d = res_q;
    rv_d  = rv_q;
    rf_d  = rf_q;
    if (ce) begin
      res_d[0] = res_n;
      rv_d[0]  = op_v;
      rf_d[0]  = ovf_n;
      for (int i = 1; i < RS; i++) begin
        res_d[i] = res_q[i-1];
        rv_d[i]  = rv_q[i-1];
        rf_d[i]  = rf_q[i-1];
      end
    end
    // A new overflow entering the output stage beats a simultaneous clear.
    ovf_d = ovf_q & ~clr_ovf;
    if (ce && rv_d[RS-1] && rf_d[RS-1]) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      // NOTE: data registers are reset too so dout reads 0 out of reset, not stale data.
      for (int i = 0; i < RS; i++) begin
        res_q[i] <= '0;
      end
      rv_q  <= '0;
      rf_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      res_q <= res_d;
      rv_q  <= rv_d;
      rf_q  <= rf_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = rv_q[RS-1];
  assign dout      = res_q[RS-1];
  assign ovf       = ovf_q;

  // The output-stage overflow bit has no reader, and ID is a tag only.
  logic unused_ok;
  assign unused_ok = ^{rf_q[RS-1], (ID != 0)};

endmodule
